vmod1_cfg_sched: RTL
====================

VMOD1_CFG_SCHED -- requirements
Module: vmod1_cfg_sched

Interface
REQ-001 Parameter aw, default 15, local-bus address width.
REQ-002 Parameter dw, default 32, local-bus data width.
REQ-003 Parameter frame_base, default 1024, lowest frame-aligned address (resonator and coupling regions).
REQ-004 clk  input  1  single clock for all logic.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 frame  input  1  mechanical frame-start pulse, one cycle wide, once per n_cycles.
REQ-007 a_valid / a_ready  input / output  1 / 1  requester A handshake (host).
REQ-008 a_addr / a_data  input  aw / dw  requester A write address and data.
REQ-009 b_valid / b_ready  input / output  1 / 1  requester B handshake (sweep engine).
REQ-010 b_addr / b_data  input  aw / dw  requester B write address and data.
REQ-011 lb_addr / lb_data  output  aw / dw  simulator bus address and data, registered.
REQ-012 lb_write  output  1  single-cycle write strobe, registered.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 wr_count  output  16  count of issued lb_write strobes.

Function
REQ-015 States: IDLE, WAIT_FRAME, ISSUE.
REQ-016 IDLE: a_ready/b_ready are combinational; at most one is high, only toward the requester chosen by the arbiter.
REQ-017 Arbitration is two-way round-robin: if both valid, grant the requester not granted last; if only one is valid, grant it.
REQ-018 A transfer occurs when valid and ready are both high; the address and data are captured in the hold register and the round-robin pointer updates.
REQ-019 After a transfer with addr < frame_base, the next state is ISSUE.
REQ-020 After a transfer with addr >= frame_base, the next state is WAIT_FRAME.
REQ-021 In WAIT_FRAME, the block moves to ISSUE on the first cycle frame=1.
REQ-022 A frame pulse coincident with the accept cycle does not count; the write waits for the next frame.
REQ-023 ISSUE: lb_write=1 for exactly one cycle, lb_addr/lb_data equal to the hold register, wr_count increments by 1, then IDLE.
REQ-024 Latency, non-deferred: lb_write is high on the cycle after the accept.
REQ-025 Latency, deferred: lb_write is high on the cycle after the frame pulse.
REQ-026 Maximum throughput is one write per 2 cycles; both ready outputs are low in WAIT_FRAME and ISSUE.
REQ-027 lb_addr and lb_data hold their last issued values between writes.
REQ-028 wr_count wraps from 65535 to 0.
REQ-029 Requester signals are ignored outside IDLE; a valid that is not granted stays pending, with no drop and no reorder within a requester.
REQ-030 A frame pulse in IDLE or ISSUE has no effect.

Reset
REQ-031 Reset values: state IDLE, lb_write 0, lb_addr 0, lb_data 0, wr_count 0, busy 0, a_ready 0, b_ready 0, round-robin pointer set so A wins the first contention.
REQ-032 Reset asserted mid-operation discards any held or deferred transaction; no lb_write is produced for it after release.
REQ-033 Reset assertion forces the outputs asynchronously; release takes effect on the next clk edge.

Structure
REQ-034 Shared package vmod1_cfg_pkg holds the state encoding, the frame_base default, and the aw/dw defaults.
REQ-035 One sub-module, rr_arb2: two-input round-robin arbiter with grant vector and pointer update on accept.
REQ-036 The block drives the existing lb_addr/lb_data/lb_write ports of the single-cavity emulator directly; it adds no decode logic.

Verification
REQ-037 Reset, then A writes addr 65 data 0x1234 -> lb_write one cycle later with lb_addr 65, lb_data 0x1234; wr_count=1.
REQ-038 A and B valid simultaneously in three consecutive rounds after reset -> issue order A, B, A; every write is 2 cycles after the previous one.
REQ-039 B writes addr 1030, frame pulses 9 cycles later -> lb_write 10 cycles after the accept; a_ready stays low throughout, even with a_valid held high.
REQ-040 Deferred accept coincident with a frame pulse, frame period 14 -> lb_write 15 cycles after the accept.
REQ-041 reset_n pulled low while in WAIT_FRAME on addr 2048, released, frame pulses -> no lb_write, wr_count=0, busy=0.
REQ-042 wr_count preset by 65536 non-deferred writes -> wraps to 0; lb_addr/lb_data hold the last issued values while idle.

Source files
------------

// File: rtl/vmod1_cfg_pkg.sv
// Shared types and defaults for the frame-aligned config write scheduler.
package vmod1_cfg_pkg;
  localparam int AW_DEF         = 15;
  localparam int DW_DEF         = 32;
  localparam int FRAME_BASE_DEF = 1024;
  localparam int CNT_W_DEF      = 16;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_ISSUE      = 2'd2
  } state_t;
endpackage

// File: rtl/vmod1_cfg_sched_rr_arb2.sv
// Two-input round-robin arbiter; bit 0 is requester A, bit 1 is requester B.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);
  // Set when B should win the next contention; reset favours A.
  logic prefer_b;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = prefer_b ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    prefer_b <= 1'b0;
    else if (accept) prefer_b <= gnt[0];
  end
endmodule

// File: rtl/vmod1_cfg_sched.sv
// Arbitrates two config-write requesters onto the emulator local bus, deferring
// frame-region writes (addr >= frame_base) to the cycle after the next frame pulse.
module vmod1_cfg_sched
  import vmod1_cfg_pkg::*;
#(
  parameter int aw         = AW_DEF,
  parameter int dw         = DW_DEF,
  parameter int frame_base = FRAME_BASE_DEF,
  parameter int cnt_w      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [aw-1:0]    a_addr,
  input  logic [dw-1:0]    a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [aw-1:0]    b_addr,
  input  logic [dw-1:0]    b_data,
  output logic [aw-1:0]    lb_addr,
  output logic [dw-1:0]    lb_data,
  output logic             lb_write,
  output logic             busy,
  output logic [cnt_w-1:0] wr_count
);
  localparam int unsigned FB = frame_base;

  state_t         state;
  logic [1:0]     req, gnt;
  logic           accept, sel_defer;
  logic [aw-1:0]  sel_addr, hold_addr;
  logic [dw-1:0]  sel_data, hold_data;

  assign req = {b_valid, a_valid};

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state == ST_IDLE),
    .req     (req),
    .accept  (accept),
    .gnt     (gnt)
  );

  assign a_ready   = gnt[0];
  assign b_ready   = gnt[1];
  assign accept    = |(gnt & req);
  assign sel_addr  = gnt[1] ? b_addr : a_addr;
  assign sel_data  = gnt[1] ? b_data : a_data;
  assign sel_defer = (32'(sel_addr) >= FB);
  assign busy      = (state != ST_IDLE);

  // lb_write is raised on entry to ISSUE so the strobe lands in the ISSUE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      hold_addr <= '0;
      hold_data <= '0;
      lb_addr   <= '0;
      lb_data   <= '0;
      lb_write  <= 1'b0;
      wr_count  <= '0;
    end else begin
      lb_write <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          hold_addr <= sel_addr;
          hold_data <= sel_data;
          if (sel_defer) begin
            state <= ST_WAIT_FRAME;
          end else begin
            state    <= ST_ISSUE;
            lb_write <= 1'b1;
            lb_addr  <= sel_addr;
            lb_data  <= sel_data;
            wr_count <= wr_count + cnt_w'(1);
          end
        end
        ST_WAIT_FRAME: if (frame) begin
          state    <= ST_ISSUE;
          lb_write <= 1'b1;
          lb_addr  <= hold_addr;
          lb_data  <= hold_data;
          wr_count <= wr_count + cnt_w'(1);
        end
        ST_ISSUE: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end
endmodule
